// File: rtl/cell_core_issue_ctrl_pkg.sv
// Shared cell-core ISA definitions: value/immediate/register types, opcodes and the
// writes_rd() classifier used by the issue controller and its hazard unit.
package cell_core_issue_ctrl_pkg;

    localparam int register_length = 16;
    localparam int NUM_REGS        = 8;
    localparam int REG_IDX_W       = $clog2(NUM_REGS);

    typedef logic [register_length-1:0] value_t;
    typedef logic [register_length-1:0] immediate_t;
    typedef logic [REG_IDX_W-1:0]       reg_idx_t;

    // Encodings 11..15 are unassigned and behave as NOPs.
    typedef enum logic [3:0] {
        OP_LI   = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_NOR  = 4'd5,
        OP_SEQ  = 4'd6,
        OP_SLT  = 4'd7,
        OP_MUL  = 4'd8,
        OP_SHR  = 4'd9,
        OP_FMUL = 4'd10,
        OP_NOP  = 4'd15
    } opcode_t;

    typedef struct packed {
        opcode_t    opcode;
        reg_idx_t   rd;
        reg_idx_t   rs1;
        reg_idx_t   rs2;
        immediate_t immediate;
    } instruction_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_EX = 2'd1,
        FWD_WB = 2'd2
    } fwd_sel_t;

    function automatic logic writes_rd(opcode_t op);
        case (op)
            OP_LI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
            OP_SEQ, OP_SLT, OP_MUL, OP_SHR, OP_FMUL: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cell_core_issue_ctrl_hazard.sv
// RAW hazard detection and operand source selection for the ID stage.
// EX has priority over WB since it holds the younger producer.
module cell_core_hazard_unit
    import cell_core_issue_ctrl_pkg::*;
#(
    parameter bit FORWARDING = 1'b0
) (
    input  opcode_t  id_opcode,
    input  reg_idx_t id_rs1,
    input  reg_idx_t id_rs2,
    input  logic     ex_valid,
    input  logic     ex_writes,
    input  reg_idx_t ex_rd,
    input  logic     wb_valid,
    input  logic     wb_writes,
    input  reg_idx_t wb_rd,
    output fwd_sel_t fwd_sel_a,
    output fwd_sel_t fwd_sel_b,
    output logic     hazard
);

    logic uses_rs, ex_hit, wb_hit;

    assign uses_rs = (id_opcode != OP_LI);
    assign ex_hit  = ex_valid && ex_writes;
    assign wb_hit  = wb_valid && wb_writes;

    always_comb begin
        fwd_sel_a = FWD_RF;
        fwd_sel_b = FWD_RF;
        if (uses_rs) begin
            if (ex_hit && id_rs1 == ex_rd)      fwd_sel_a = FWD_EX;
            else if (wb_hit && id_rs1 == wb_rd) fwd_sel_a = FWD_WB;
            if (ex_hit && id_rs2 == ex_rd)      fwd_sel_b = FWD_EX;
            else if (wb_hit && id_rs2 == wb_rd) fwd_sel_b = FWD_WB;
        end
    end

    // With bypassing every match is resolved by the operand mux, so nothing stalls.
    assign hazard = !FORWARDING && ((fwd_sel_a != FWD_RF) || (fwd_sel_b != FWD_RF));

endmodule

// File: rtl/cell_core_issue_ctrl.sv
// Cell-core issue controller: ID -> EX -> WB pipeline around an external ALU and RF.
// Define CELL_CORE_FORWARDING_EN to bypass operands instead of stalling on RAW hazards.
module cell_core_issue_ctrl
    import cell_core_issue_ctrl_pkg::*;
#(
    parameter int RETIRE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    input  instruction_t            instr,
    output logic                    instr_ready,
    input  logic                    freeze,
    output reg_idx_t                rf_rs1_idx,
    output reg_idx_t                rf_rs2_idx,
    input  value_t                  rf_rs1_data,
    input  value_t                  rf_rs2_data,
    output logic                    rf_we,
    output reg_idx_t                rf_wr_idx,
    output value_t                  rf_wr_data,
    output opcode_t                 alu_opcode,
    output immediate_t              alu_immediate,
    output value_t                  alu_first,
    output value_t                  alu_second,
    input  value_t                  alu_result,
    output logic                    busy,
    output logic [RETIRE_CNT_W-1:0] retired_count
);

`ifdef CELL_CORE_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif
    localparam int STAGES = 2;

    // vld_pipe[1] = EX valid, vld_pipe[2] = WB valid
    logic [STAGES:1] vld_pipe;

    opcode_t    ex_opcode;
    immediate_t ex_imm;
    reg_idx_t   ex_rd;
    value_t     ex_a, ex_b;

    logic       wb_writes;
    reg_idx_t   wb_rd;
    value_t     wb_data;

    fwd_sel_t   fwd_sel_a, fwd_sel_b;
    logic       hazard, id_fire;
    value_t     op_a, op_b;

    cell_core_hazard_unit #(.FORWARDING(FWD_EN)) u_hazard (
        .id_opcode (instr.opcode),
        .id_rs1    (instr.rs1),
        .id_rs2    (instr.rs2),
        .ex_valid  (vld_pipe[1]),
        .ex_writes (writes_rd(ex_opcode)),
        .ex_rd     (ex_rd),
        .wb_valid  (vld_pipe[2]),
        .wb_writes (wb_writes),
        .wb_rd     (wb_rd),
        .fwd_sel_a (fwd_sel_a),
        .fwd_sel_b (fwd_sel_b),
        .hazard    (hazard)
    );

    assign rf_rs1_idx  = instr.rs1;
    assign rf_rs2_idx  = instr.rs2;
    assign instr_ready = !rst && !freeze && !hazard;
    assign id_fire     = instr_valid && instr_ready;

    // Without forwarding a non-RF select only occurs while stalled, so it is never captured.
    always_comb begin
        op_a = rf_rs1_data;
        op_b = rf_rs2_data;
        case (fwd_sel_a)
            FWD_EX:  op_a = alu_result;
            FWD_WB:  op_a = wb_data;
            default: ;
        endcase
        case (fwd_sel_b)
            FWD_EX:  op_b = alu_result;
            FWD_WB:  op_b = wb_data;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe      <= '0;
            ex_opcode     <= OP_LI;
            ex_imm        <= '0;
            ex_rd         <= '0;
            ex_a          <= '0;
            ex_b          <= '0;
            wb_writes     <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            retired_count <= '0;
        end else if (!freeze) begin
            vld_pipe <= {vld_pipe[1], id_fire};
            if (id_fire) begin
                ex_opcode <= instr.opcode;
                ex_imm    <= instr.immediate;
                ex_rd     <= instr.rd;
                ex_a      <= op_a;
                ex_b      <= op_b;
            end
            wb_writes <= writes_rd(ex_opcode);
            wb_rd     <= ex_rd;
            wb_data   <= alu_result;
            if (vld_pipe[2])
                retired_count <= retired_count + RETIRE_CNT_W'(1);
        end
    end

    // rst gating drops a WB-stage write in the reset cycle itself.
    assign rf_we         = vld_pipe[2] && wb_writes && !freeze && !rst;
    assign rf_wr_idx     = wb_rd;
    assign rf_wr_data    = wb_data;
    assign alu_opcode    = ex_opcode;
    assign alu_immediate = ex_imm;
    assign alu_first     = ex_a;
    assign alu_second    = ex_b;
    assign busy          = |vld_pipe;

endmodule

// File: tb/tb_cell_core_issue_ctrl.sv
// Bench for cell_core_issue_ctrl: directed vector tables, multi-cycle corner sequences
// and a random stream checked against an in-order architectural model.
module tb_cell_core_issue_ctrl;
    import cell_core_issue_ctrl_pkg::*;

    logic         clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, freeze = 1'b0;
    instruction_t instr = '0;
    logic         instr_ready, rf_we, busy;
    reg_idx_t     rf_rs1_idx, rf_rs2_idx, rf_wr_idx;
    value_t       rf_rs1_data, rf_rs2_data, rf_wr_data, alu_first, alu_second, alu_result;
    opcode_t      alu_opcode;
    immediate_t   alu_immediate;
    logic [15:0]  retired_count;

    cell_core_issue_ctrl #(.RETIRE_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .freeze(freeze),
        .rf_rs1_idx(rf_rs1_idx), .rf_rs2_idx(rf_rs2_idx),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .rf_we(rf_we), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
        .alu_opcode(alu_opcode), .alu_immediate(alu_immediate),
        .alu_first(alu_first), .alu_second(alu_second), .alu_result(alu_result),
        .busy(busy), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // ALU behaviour model; LI passes the immediate, unassigned opcodes produce 0.
    function automatic value_t alu_fn(logic [3:0] op, value_t a, value_t b, value_t imm);
        logic [31:0] p;
        p = {16'd0, a} * {16'd0, b};
        case (op)
            4'd0:    return imm;
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return ~(a | b);
            4'd6:    return (a == b) ? 16'd1 : 16'd0;
            4'd7:    return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'd8:    return p[15:0];
            4'd9:    return a >> b[3:0];
            4'd10:   return p[23:8];
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic tb_writes(logic [3:0] op);
        return op <= 4'd10;
    endfunction

    function automatic instruction_t mk(opcode_t op, int rd, int rs1, int rs2, int imm);
        instruction_t m;
        m.opcode    = op;
        m.rd        = reg_idx_t'(rd);
        m.rs1       = reg_idx_t'(rs1);
        m.rs2       = reg_idx_t'(rs2);
        m.immediate = immediate_t'(imm);
        return m;
    endfunction

    // Environment: register file and ALU the controller drives.
    value_t env_rf [NUM_REGS];
    assign rf_rs1_data = env_rf[rf_rs1_idx];
    assign rf_rs2_data = env_rf[rf_rs2_idx];
    assign alu_result  = alu_fn(alu_opcode, alu_first, alu_second, alu_immediate);

    // Architectural model: each accepted instruction executes in order against arch_rf,
    // and the resulting write is expected later on the RF write port.
    typedef struct { reg_idx_t rd; value_t d; } wr_t;
    wr_t         exp_q[$];
    value_t      arch_rf [NUM_REGS];
    logic [15:0] acc_cnt = '0;
    int          wcnt = 0;
    logic        prev_rst = 1'b1;

    initial begin
        for (int i = 0; i < NUM_REGS; i++) begin
            env_rf[i]  <= '0;
            arch_rf[i] = '0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                chk("rst_cycle_we", int'(rf_we), 0);
                exp_q.delete();
                for (int i = 0; i < NUM_REGS; i++) arch_rf[i] = env_rf[i];
                acc_cnt  = '0;
                prev_rst = 1'b1;
            end else begin
                if (prev_rst) chk("post_rst_we", int'(rf_we), 0);
                prev_rst = 1'b0;
                if (freeze) chk("frozen_we", int'(rf_we), 0);
                if (rf_we) begin
                    wcnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write_idx", int'(rf_wr_idx), -1);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        chk("wr_idx", int'(rf_wr_idx), int'(e.rd));
                        chk("wr_data", int'(rf_wr_data), int'(e.d));
                    end
                    env_rf[rf_wr_idx] <= rf_wr_data;
                end
                if (instr_valid && instr_ready) begin
                    value_t r;
                    r = alu_fn(instr.opcode, arch_rf[instr.rs1], arch_rf[instr.rs2], instr.immediate);
                    if (tb_writes(instr.opcode)) begin
                        exp_q.push_back('{instr.rd, r});
                        arch_rf[instr.rd] = r;
                    end
                    acc_cnt = acc_cnt + 16'd1;
                end
            end
        end
    end

    typedef struct { logic v; instruction_t ins; int rdy; int we; int idx; int data; } vec_t;
    vec_t tbl[$];

    function automatic vec_t vv(logic v, instruction_t ins, int rdy, int we, int idx, int data);
        vec_t t;
        t.v = v; t.ins = ins; t.rdy = rdy; t.we = we; t.idx = idx; t.data = data;
        return t;
    endfunction

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            freeze      = 1'b0;
        end
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        rst = 1'b1; instr_valid = 1'b0; freeze = 1'b0;
        for (int i = 1; i < n; i++) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        instruction_t nop, li1, li2, li3, li1b, add, li1c, orr, sub;
        instruction_t lst[5];
        int idx, w0, pend;
        value_t r7_before;

        nop  = mk(OP_NOP, 0, 0, 0, 0);
        li1  = mk(OP_LI, 1, 0, 0, 5);
        li2  = mk(OP_LI, 2, 0, 0, 7);
        li3  = mk(OP_LI, 3, 0, 0, 9);
        li1b = mk(OP_LI, 1, 0, 0, 5);
        add  = mk(OP_ADD, 2, 1, 1, 0);
        li1c = mk(OP_LI, 1, 0, 0, 3);
        orr  = mk(OP_OR, 4, 5, 6, 0);
        sub  = mk(OP_SUB, 2, 1, 1, 0);

        // Reset held 3 cycles with a valid instruction offered.
        instr_valid = 1'b1;
        instr       = li1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #3;
            chk("rst_ready", int'(instr_ready), 0);
            chk("rst_we", int'(rf_we), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_count", int'(retired_count), 0);
        end
        @(negedge clk);
        rst = 1'b0; instr_valid = 1'b0;

        // Independent stream, then EX-distance and WB-distance RAW.
        tbl.push_back(vv(1, li1, 1, 0, 0, 0));
        tbl.push_back(vv(1, li2, 1, 0, 0, 0));
        tbl.push_back(vv(1, li3, 1, 1, 1, 5));
        tbl.push_back(vv(0, nop, 1, 1, 2, 7));
        tbl.push_back(vv(0, nop, 1, 1, 3, 9));
`ifdef CELL_CORE_FORWARDING_EN
        tbl.push_back(vv(1, li1b, 1, 0, 0, 0));
        tbl.push_back(vv(1, add,  1, 0, 0, 0));
        tbl.push_back(vv(0, nop,  1, 1, 1, 5));
        tbl.push_back(vv(0, nop,  1, 1, 2, 10));
        tbl.push_back(vv(1, li1c, 1, 0, 0, 0));
        tbl.push_back(vv(1, orr,  1, 0, 0, 0));
        tbl.push_back(vv(1, sub,  1, 1, 1, 3));
        tbl.push_back(vv(0, nop,  1, 1, 4, 0));
        tbl.push_back(vv(0, nop,  1, 1, 2, 0));
`else
        tbl.push_back(vv(1, li1b, 1, 0, 0, 0));
        tbl.push_back(vv(1, add,  0, 0, 0, 0));
        tbl.push_back(vv(1, add,  0, 1, 1, 5));
        tbl.push_back(vv(1, add,  1, 0, 0, 0));
        tbl.push_back(vv(0, nop,  1, 0, 0, 0));
        tbl.push_back(vv(0, nop,  1, 1, 2, 10));
        tbl.push_back(vv(1, li1c, 1, 0, 0, 0));
        tbl.push_back(vv(1, orr,  1, 0, 0, 0));
        tbl.push_back(vv(1, sub,  0, 1, 1, 3));
        tbl.push_back(vv(1, sub,  1, 1, 4, 0));
        tbl.push_back(vv(0, nop,  1, 0, 0, 0));
        tbl.push_back(vv(0, nop,  1, 1, 2, 0));
`endif
        foreach (tbl[i]) begin
            @(negedge clk);
            instr_valid = tbl[i].v;
            instr       = tbl[i].ins;
            #3;
            chk($sformatf("tbl%0d_ready", i), int'(instr_ready), tbl[i].rdy);
            chk($sformatf("tbl%0d_we", i), int'(rf_we), tbl[i].we);
            if (tbl[i].we != 0) begin
                chk($sformatf("tbl%0d_idx", i), int'(rf_wr_idx), tbl[i].idx);
                chk($sformatf("tbl%0d_data", i), int'(rf_wr_data), tbl[i].data);
            end
        end
        idle(3);

        // Freeze for 4 cycles in the middle of a 5-instruction stream.
        do_reset(2);
        for (int i = 0; i < 5; i++) lst[i] = mk(OP_LI, i + 1, 0, 0, 'h11 + i);
        idx = 0;
        w0  = wcnt;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            freeze      = (c >= 2 && c < 6);
            instr_valid = (idx < 5);
            instr       = lst[(idx < 5) ? idx : 0];
            #3;
            if (instr_valid && instr_ready) idx++;
        end
        idle(2);
        chk("frz_accepted", idx, 5);
        chk("frz_writes", wcnt - w0, 5);
        chk("frz_retired", int'(retired_count), 5);
        chk("frz_r5", int'(env_rf[5]), 'h15);

        // Reset while an LI sits in EX: its write must never appear.
        r7_before = env_rf[7];
        @(negedge clk);
        instr_valid = 1'b1; instr = mk(OP_LI, 7, 0, 0, 'h55);
        @(negedge clk);
        rst = 1'b1; instr_valid = 1'b0;
        #3;
        chk("rstex_we_rst", int'(rf_we), 0);
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("rstex_we_after", int'(rf_we), 0);
        idle(3);
        chk("rstex_r7", int'(env_rf[7]), int'(r7_before));
        chk("rstex_busy", int'(busy), 0);

        // NOP retires without writing; counter wraps at 16 bits.
        do_reset(1);
        @(negedge clk);
        instr_valid = 1'b1; instr = mk(OP_NOP, 3, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            #3;
            chk("nop_we", int'(rf_we), 0);
        end
        chk("nop_count", int'(retired_count), 1);
        for (int i = 0; i < 65534; i++) begin
            @(negedge clk);
            instr_valid = 1'b1;
        end
        idle(3);
        chk("wrap_pre", int'(retired_count), 'hFFFF);
        @(negedge clk);
        instr_valid = 1'b1;
        idle(3);
        chk("wrap_zero", int'(retired_count), 0);

        // Random stream with random freeze against the architectural model.
        do_reset(2);
        pend = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (pend == 0) begin
                instr_valid = ($urandom_range(3) != 0);
                instr = mk(opcode_t'(4'($urandom_range(15))), $urandom_range(7),
                           $urandom_range(7), $urandom_range(7), $urandom_range(16'hFFFF));
            end
            freeze = ($urandom_range(7) == 0);
            #3;
            pend = (instr_valid && !instr_ready) ? 1 : 0;
        end
        idle(4);
        chk("rand_pending", exp_q.size(), 0);
        chk("rand_retired", int'(retired_count), int'(acc_cnt));
        chk("rand_busy", int'(busy), 0);
        for (int i = 0; i < NUM_REGS; i++)
            chk($sformatf("rand_r%0d", i), int'(env_rf[i]), int'(arch_rf[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
